// File: rtl/shift_rotate_unit_if.sv
// rtl/shift_rotate_unit_if.sv - command handshake and status bundle for shift_rotate_unit
interface shift_rotate_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_amt, data_in,
        input  cmd_ready, q, sout, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_amt, data_in,
        output cmd_ready, q, sout, busy, done
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// rtl/shift_rotate_unit.sv - universal shift/rotate register, one position per clock; SRU_ABORT_EN adds abort input
module shift_rotate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic resetn,
`ifdef SRU_ABORT_EN
    input  logic abort,
`endif
    shift_rotate_unit_if.slave bus
);
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_ROR   = 3'b010;
    localparam logic [2:0] OP_ROL   = 3'b011;
    localparam logic [2:0] OP_LSR   = 3'b100;
    localparam logic [2:0] OP_LSL   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q;
    logic             sout_q;
    logic             done_q;
    logic             busy_q;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       op_q;

    logic             abort_i;
    logic             accept;
    logic             is_shift;
    logic             start_run;
    logic             run_step;
    logic             done_d;

`ifdef SRU_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Returns {bit shifted out, new register value} for a single-position step.
    function automatic logic [WIDTH:0] step1(input logic [2:0] op, input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        r = {v[0], v[0], v[WIDTH-1:1]};
        case (op)
            OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_LSR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_LSL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: ;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_run) state_d = RUN;
            RUN:  if (abort_i || count_q == CNT_ONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == IDLE);
        accept        = bus.cmd_valid && (state_q == IDLE);
        is_shift      = (bus.cmd_op != OP_NOP) && (bus.cmd_op != OP_LOAD) && (bus.cmd_op != OP_CLEAR);
        start_run     = accept && is_shift && (bus.cmd_amt != '0);
        run_step      = (state_q == RUN) && !abort_i;
        done_d        = (accept && !start_run) ||
                        ((state_q == RUN) && (abort_i || count_q == CNT_ONE));
    end

    // Single-cycle commands act at the accept edge; shifts run from the latched op.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
            op_q    <= OP_NOP;
        end else begin
            done_q <= done_d;
            busy_q <= (state_d == RUN);
            if (accept) begin
                if (bus.cmd_op == OP_LOAD) begin
                    q_q <= bus.data_in;
                end else if (bus.cmd_op == OP_CLEAR) begin
                    q_q <= '0;
                end else if (start_run) begin
                    op_q    <= bus.cmd_op;
                    count_q <= bus.cmd_amt;
                end
            end else if (run_step) begin
                {sout_q, q_q} <= step1(op_q, q_q);
                count_q       <= count_q - CNT_ONE;
            end
        end
    end

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb/tb_shift_rotate_unit.sv - directed bench with cycle-level reference model for shift_rotate_unit
module tb_shift_rotate_unit;
    localparam int W = 8;
    localparam int C = 4;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ROR = 3'd2, ROL = 3'd3;
    localparam logic [2:0] LSR = 3'd4, LSL = 3'd5, ASR = 3'd6, CLR = 3'd7;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic abort = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    shift_rotate_unit_if #(.WIDTH(W), .CNT_W(C)) bus ();

    shift_rotate_unit #(.WIDTH(W), .CNT_W(C)) dut (
        .clk    (clk),
        .resetn (resetn),
`ifdef SRU_ABORT_EN
        .abort  (abort),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: remaining-step count stands in for the whole FSM.
    logic [W-1:0] m_q = '0;
    logic         m_sout = 1'b0;
    logic         m_done = 1'b0;
    logic [2:0]   m_op = NOP;
    int           m_rem = 0;

    function automatic logic [W:0] mstep(input logic [2:0] op, input logic [W-1:0] v);
        case (op)
            ROR:     return {v[0],   (v >> 1) | (v << (W - 1))};
            ROL:     return {v[W-1], (v << 1) | (v >> (W - 1))};
            LSR:     return {v[0],   v >> 1};
            LSL:     return {v[W-1], v << 1};
            default: return {v[0],   W'($signed(v) >>> 1)};
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [W-1:0] nq;
        logic         ns, nd, ab;
        logic [2:0]   nop;
        int           nrem;
        nq = m_q; ns = m_sout; nd = 1'b0; nop = m_op; nrem = m_rem;
`ifdef SRU_ABORT_EN
        ab = abort;
`else
        ab = 1'b0;
`endif
        if (!resetn) begin
            nq = '0; ns = 1'b0; nrem = 0;
        end else if (nrem == 0) begin
            if (bus.cmd_valid) begin
                nd = 1'b1;
                if (bus.cmd_op == LOAD) nq = bus.data_in;
                else if (bus.cmd_op == CLR) nq = '0;
                else if (bus.cmd_op != NOP && bus.cmd_amt != 0) begin
                    nop = bus.cmd_op; nrem = int'(bus.cmd_amt); nd = 1'b0;
                end
            end
        end else if (ab) begin
            nrem = 0; nd = 1'b1;
        end else begin
            {ns, nq} = mstep(nop, nq);
            nrem = nrem - 1;
            nd = (nrem == 0);
        end
        m_q <= nq; m_sout <= ns; m_done <= nd; m_op <= nop; m_rem <= nrem;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks = checks + 5;
            if (bus.q !== m_q) begin
                errors++; $display("FAIL model_q: got %h expected %h at %0t", bus.q, m_q, $time);
            end
            if (bus.sout !== m_sout) begin
                errors++; $display("FAIL model_sout: got %b expected %b at %0t", bus.sout, m_sout, $time);
            end
            if (bus.done !== m_done) begin
                errors++; $display("FAIL model_done: got %b expected %b at %0t", bus.done, m_done, $time);
            end
            if (bus.busy !== (m_rem != 0)) begin
                errors++; $display("FAIL model_busy: got %b expected %b at %0t", bus.busy, m_rem != 0, $time);
            end
            if (bus.cmd_ready !== (m_rem == 0)) begin
                errors++; $display("FAIL model_ready: got %b expected %b at %0t", bus.cmd_ready, m_rem == 0, $time);
            end
        end
    end

    task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [C-1:0] amt, input logic [W-1:0] d);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_amt = amt; bus.data_in = d;
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = NOP; bus.cmd_amt = '0; bus.data_in = '0;
        cyc(2);
        chk_en = 1'b1;
        lit("reset_q", bus.q, 8'h00);
        lit("reset_busy", W'(bus.busy), 8'h00);
        lit("reset_ready", W'(bus.cmd_ready), 8'h01);
        resetn = 1'b1;

        cmd(LOAD, 4'd0, 8'hA5);
        lit("load_q", bus.q, 8'hA5);
        lit("load_done", W'(bus.done), 8'h01);
        lit("load_busy", W'(bus.busy), 8'h00);
        cyc();
        lit("load_done_drop", W'(bus.done), 8'h00);

        cmd(ROR, 4'd3, 8'h00);
        lit("ror_ready_low", W'(bus.cmd_ready), 8'h00);
        cyc(); lit("ror_step1", bus.q, 8'hD2);
        cyc(); lit("ror_step2", bus.q, 8'h69);
        cyc(); lit("ror_step3", bus.q, 8'hB4);
        lit("ror_done", W'(bus.done), 8'h01);
        lit("ror_sout", W'(bus.sout), 8'h01);

        cmd(LOAD, 4'd0, 8'h90);
        cmd(ASR, 4'd2, 8'h00);
        cyc(); lit("asr_step1", bus.q, 8'hC8);
        cyc(); lit("asr_step2", bus.q, 8'hE4);
        lit("asr_sout", W'(bus.sout), 8'h00);

        cmd(LOAD, 4'd0, 8'hFF);
        cmd(LSL, 4'd9, 8'h00);
        cyc(8);
        lit("lsl_q8", bus.q, 8'h00);
        lit("lsl_busy8", W'(bus.busy), 8'h01);
        cyc();
        lit("lsl_done", W'(bus.done), 8'h01);
        lit("lsl_sout", W'(bus.sout), 8'h00);

        cmd(LOAD, 4'd0, 8'h01);
        bus.cmd_valid = 1'b1; bus.cmd_op = ROL; bus.cmd_amt = 4'd10;
        cyc();
        bus.cmd_op = LOAD; bus.data_in = 8'h33;
        cyc(10);
        bus.cmd_valid = 1'b0;
        lit("rol10_q", bus.q, 8'h04);
        lit("rol10_done", W'(bus.done), 8'h01);

        cmd(ROL, 4'd10, 8'h00);
        cyc(3);
        resetn = 1'b0;
        cyc();
        lit("midrun_reset_q", bus.q, 8'h00);
        lit("midrun_reset_busy", W'(bus.busy), 8'h00);
        lit("midrun_reset_done", W'(bus.done), 8'h00);
        lit("midrun_reset_ready", W'(bus.cmd_ready), 8'h01);
        resetn = 1'b1;

        cmd(LOAD, 4'd0, 8'h3C);
        cmd(LSR, 4'd0, 8'h00);
        lit("lsr0_q", bus.q, 8'h3C);
        lit("lsr0_done", W'(bus.done), 8'h01);
        lit("lsr0_busy", W'(bus.busy), 8'h00);
        cmd(LOAD, 4'd0, 8'h5A);
        lit("load_in_done_cycle", bus.q, 8'h5A);

`ifdef SRU_ABORT_EN
        cmd(LOAD, 4'd0, 8'h01);
        cmd(ROL, 4'd6, 8'h00);
        cyc(2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        lit("abort_q", bus.q, 8'h04);
        lit("abort_done", W'(bus.done), 8'h01);
        lit("abort_busy", W'(bus.busy), 8'h00);
        lit("abort_ready", W'(bus.cmd_ready), 8'h01);
        cyc();
        lit("abort_done_drop", W'(bus.done), 8'h00);
`endif

        cmd(CLR, 4'd0, 8'h00);
        lit("clear_q", bus.q, 8'h00);
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
- Parametrised universal shift/rotate register with parallel load. Generalises the 8-bit rotating register to WIDTH bits and multi-position commands.
- Commands arrive over a valid/ready handshake. Multi-position shifts run one position per clock under a small FSM, with busy and done status.
- Sits between switch/ALU datapaths and display/register logic. Serves as a reusable operand register for the ALU datapath.

Parameters:
- WIDTH, 8, data register width in bits (>=2).
- CNT_W, 4, width of the shift-amount field; maximum amount is 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  unit can accept a command; equals (state==IDLE).
- cmd_op  input  3  opcode, listed under Behaviour.
- cmd_amt  input  CNT_W  number of positions for shift/rotate ops.
- data_in  input  WIDTH  parallel-load data.
- q  output  WIDTH  register contents.
- sout  output  1  last bit shifted or rotated out.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (resetn=0 at a clk edge): q=0, sout=0, done=0, busy=0, state=IDLE. Reset overrides everything, including an operation in progress; any partial shift is discarded.
- Opcodes:
  - 000 NOP
  - 001 LOAD (q<=data_in)
  - 010 ROR
  - 011 ROL
  - 100 LSR (fill 0 at MSB)
  - 101 LSL (fill 0 at LSB)
  - 110 ASR (fill with current q[WIDTH-1])
  - 111 CLEAR (q<=0)
- Accept: a command is accepted on an edge where cmd_valid && cmd_ready. When cmd_ready=0, cmd_valid is ignored and the command is lost; the source must hold it.
- Single-cycle ops: NOP, LOAD, CLEAR, or any shift op with cmd_amt=0.
  - The effect is applied at the accept edge. done=1 for the following cycle. State stays IDLE.
  - sout is unchanged by these ops.
- Multi-cycle ops: a shift op with cmd_amt=k>=1.
  - At the accept edge, latch op and count=k, then go to RUN. busy=1 and cmd_ready=0.
  - Each RUN edge performs exactly one 1-position step and decrements count.
  - On the edge where count goes 1->0: perform the final step, return to IDLE, and set done=1 for one cycle.
  - Accept at edge t gives steps at edges t+1..t+k; q is final and done is high after edge t+k.
  - A new command may be accepted in the cycle done is high.
- sout per step:
  - ROR and right shifts: q[0] before the step.
  - ROL and LSL: q[WIDTH-1] before the step.
- Boundaries:
  - k>=WIDTH is executed literally, one step per cycle.
  - ROR/ROL by WIDTH returns the original value.
  - LSR/LSL by >=WIDTH yields 0.
  - ASR by >=WIDTH-1 yields all copies of the sign bit.
- data_in and cmd_op are sampled only at the accept edge; changes during RUN have no effect.
- done and busy are registered outputs.

Optional Feature:
- Macro SRU_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 at a RUN edge performs no step, returns to IDLE, and sets done=1 for one cycle.
  - q and sout keep their partial values.
  - abort is ignored in IDLE.
  - resetn has priority over abort.
- Undefined: no abort port; RUN always completes all k steps.

Test Plan (WIDTH=8, CNT_W=4):
- Reset then LOAD 0xA5 -> after accept edge q=0xA5, done high exactly 1 cycle, busy stays 0.
- From 0xA5, ROR amt=3 -> q steps D2, 69, B4; busy high 3 cycles; done after 3rd step; sout=1; cmd_ready low during RUN.
- LOAD 0x90, then ASR amt=2 -> q=C8 then E4, sout=0. Then LSL amt=9 from 0xFF -> q=00 after 8th step, 9 busy cycles, final sout=0.
- During ROL amt=10 from 0x01, drive cmd_valid with LOAD 0x33 -> ignored, q follows rotation, final q=0x04. Rerun the same command and drop resetn on the 4th RUN cycle -> next edge q=0, busy=0, done=0, cmd_ready=1.
- LSR amt=0 from 0x3C -> q stays 0x3C, done pulses, no RUN. Issue LOAD in the done cycle -> accepted.
- (SRU_ABORT_EN) From 0x01, ROL amt=6 with abort on the 3rd RUN edge -> q=0x04, done pulses once, busy=0, cmd_ready=1.
